// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice: FSM state encoding,
// requester port IDs and the byte-enable width of a 32-bit word.
// Optional feature macro used by this slice: DMEM_ARB_SUBWORD_EN.
package dmem_arb_pkg;

  // ST_RMW_WR is only ever entered when DMEM_ARB_SUBWORD_EN is defined; the
  // encoding is kept in every build so both variants share one state type.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RMW_WR = 2'd2
  } arb_state_t;

  // Requester IDs: port 0 is the core load/store unit, port 1 the debug/DMA loader.
  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DMEM_DATA_W = 32;
  localparam int BE_W        = DMEM_DATA_W / 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Two-input round-robin grant generator.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   valid     - request valids, bit 0 = port 0, bit 1 = port 1
//   update    - strobe: a grant was consumed this cycle, advance the pointer
//   grant     - one-hot grant (combinational)
//   ptr       - registered priority pointer (port favoured on a tie)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr
);

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

  // After a grant is consumed the pointer names the port that was not served,
  // so two continuously-valid requesters alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PORT_LSU;
    end else if (update) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port word-addressed data memory between the core
// load/store unit (port 0) and the debug/DMA loader (port 1). Requests use a
// valid/ready handshake, are arbitrated round-robin and answered with a
// registered one-cycle response pulse.
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   reqN_valid/ready         - request handshake for port N
//   reqN_we/addr/wdata/be    - write flag, word address, write data, byte enables
//   rspN_valid/rdata         - response pulse and read data (pre-write data on writes)
//   mem_addr/wdata/we        - registered drive of the memory inputs
//   mem_rdata                - combinational read data from the memory
// Optional feature: define DMEM_ARB_SUBWORD_EN to turn partial-byte writes into
// read-modify-write sequences. Without it the be ports are ignored.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_be,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_be,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BEW = DATA_W / 8;

  arb_state_t        state;
  logic [1:0]        valids;
  logic [1:0]        grant;
  logic              arb_ptr;
  logic              accept;
  logic              acc_port;
  logic              owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign valids = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (valids),
    .update (accept),
    .grant  (grant),
    .ptr    (arb_ptr)
  );

  // Requests are only taken while the memory is free.
  assign req0_ready = (state == ST_IDLE) && grant[0];
  assign req1_ready = (state == ST_IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;

  // Winning port: the pointer on a tie, otherwise whichever port is valid.
  assign acc_port  = (&valids) ? arb_ptr : req1_valid;
  assign sel_we    = acc_port ? req1_we    : req0_we;
  assign sel_addr  = acc_port ? req1_addr  : req0_addr;
  assign sel_wdata = acc_port ? req1_wdata : req0_wdata;

`ifdef DMEM_ARB_SUBWORD_EN
  logic [BEW-1:0]    sel_be;
  logic [BEW-1:0]    lat_be;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              sel_full;
  logic              lat_partial;

  assign sel_be      = acc_port ? req1_be : req0_be;
  assign sel_full    = (sel_be == {BEW{1'b1}});
  assign lat_partial = lat_we && (lat_be != {BEW{1'b1}});

  // Replace the enabled bytes of the current word with the new write data.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BEW-1:0]    be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BEW; i++) begin
      if (be[i]) begin
        merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return merged;
  endfunction
`else
  logic be_unused;
  assign be_unused = ^{req0_be, req1_be, BEW[0]};
`endif

  // Main FSM. The memory address/data registers are loaded at accept time so
  // that they already present the request during the ACCESS cycle; they then
  // hold until the next accept. mem_we is only high in ACCESS or RMW_WR and
  // clears asynchronously on reset, which drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= PORT_LSU;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
`ifdef DMEM_ARB_SUBWORD_EN
      lat_be     <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= acc_port;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
`ifdef DMEM_ARB_SUBWORD_EN
            lat_be    <= sel_be;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            // Partial writes read first; the write happens in RMW_WR.
            mem_we    <= sel_we && sel_full;
`else
            mem_we    <= sel_we;
`endif
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_we <= 1'b0;
          if (owner == PORT_DBG) begin
            rsp1_rdata <= mem_rdata;
          end else begin
            rsp0_rdata <= mem_rdata;
          end
`ifdef DMEM_ARB_SUBWORD_EN
          if (lat_partial) begin
            // be == 0 still takes the RMW slot but leaves memory untouched.
            mem_wdata <= merge_bytes(mem_rdata, lat_wdata, lat_be);
            mem_we    <= |lat_be;
            state     <= ST_RMW_WR;
          end else begin
            if (owner == PORT_DBG) begin
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_valid <= 1'b1;
            end
            state <= ST_IDLE;
          end
`else
          if (owner == PORT_DBG) begin
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_valid <= 1'b1;
          end
          state <= ST_IDLE;
`endif
        end
`ifdef DMEM_ARB_SUBWORD_EN
        ST_RMW_WR: begin
          mem_we <= 1'b0;
          if (owner == PORT_DBG) begin
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
`endif
        default: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_be;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_be;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int vec;
  int errs;
  int rsp0_cnt;
  int rsp1_cnt;

  // Small word memory; address bits above 3 are ignored.
  logic [31:0] mem [0:15] = '{
    32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
    32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007,
    32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000B,
    32'h1000_000C, 32'h1000_000D, 32'h1000_000E, 32'h1000_000F
  };

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (rsp0_valid) rsp0_cnt <= rsp0_cnt + 1;
    if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
  end

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_be    (req0_be),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_be    (req1_be),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_be = 4'hF;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_be = 4'hF;
    rsp0_cnt = 0; rsp1_cnt = 0;
    repeat (3) @(negedge clk);
    vec++; if (mem_we !== 1'b0) begin errs++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    vec++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errs++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid}); end
    rst = 1'b0;
    tick;
    vec++; if (mem_addr !== 32'h0) begin errs++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    vec++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin errs++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", rsp0_rdata, rsp1_rdata); end
  endtask

  task automatic test_write_read;
    req0_valid = 1; req0_we = 1; req0_addr = 5; req0_wdata = 32'hDEADBEEF; req0_be = 4'hF;
    #1;
    vec++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL wr_ready0: got %b want 1", req0_ready); end
    tick;
    req0_valid = 0;
    vec++; if (mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin errs++; $display("[TB] FAIL wr_access: we %b addr %h data %h want 1/5/deadbeef", mem_we, mem_addr, mem_wdata); end
    vec++; if (rsp0_valid !== 1'b0) begin errs++; $display("[TB] FAIL wr_rsp_early: got %b want 0", rsp0_valid); end
    tick;
    vec++; if (rsp0_valid !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("[TB] FAIL wr_rsp: valid %b we %b want 1/0", rsp0_valid, mem_we); end
    vec++; if (rsp0_rdata !== 32'h1000_0005) begin errs++; $display("[TB] FAIL wr_prewrite: got %h want 10000005", rsp0_rdata); end
    req0_valid = 1; req0_we = 0; req0_addr = 5;
    #1;
    vec++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL rd_ready0: got %b want 1", req0_ready); end
    tick;
    req0_valid = 0;
    vec++; if (mem_we !== 1'b0 || mem_addr !== 32'd5) begin errs++; $display("[TB] FAIL rd_access: we %b addr %h want 0/5", mem_we, mem_addr); end
    tick;
    vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF) begin errs++; $display("[TB] FAIL rd_rsp: valid %b data %h want 1/deadbeef", rsp0_valid, rsp0_rdata); end
    tick;
    vec++; if (rsp0_valid !== 1'b0) begin errs++; $display("[TB] FAIL rd_rsp_pulse: got %b want 0", rsp0_valid); end
    vec++; if (rsp1_cnt !== 0) begin errs++; $display("[TB] FAIL wr_rd_rsp1_count: got %0d want 0", rsp1_cnt); end
  endtask

  task automatic test_fairness;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_data;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick;
    req0_valid = 1; req0_we = 0; req0_addr = 1;
    req1_valid = 1; req1_we = 0; req1_addr = 2;
    for (int t = 0; t < 4; t++) begin
      exp_rsp = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      vec++; if ({req1_ready, req0_ready} !== exp_rsp) begin errs++; $display("[TB] FAIL fair_grant_%0d: got %b want %b", t, {req1_ready, req0_ready}, exp_rsp); end
      tick;
      vec++; if ({req1_ready, req0_ready} !== 2'b00) begin errs++; $display("[TB] FAIL fair_busy_%0d: got %b want 00", t, {req1_ready, req0_ready}); end
      tick;
      vec++; if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin errs++; $display("[TB] FAIL fair_rsp_%0d: got %b want %b", t, {rsp1_valid, rsp0_valid}, exp_rsp); end
      exp_data = (t % 2 == 0) ? 32'h1000_0001 : 32'h1000_0002;
      if (t % 2 == 0) begin
        vec++; if (rsp0_rdata !== exp_data) begin errs++; $display("[TB] FAIL fair_data_%0d: got %h want %h", t, rsp0_rdata, exp_data); end
      end else begin
        vec++; if (rsp1_rdata !== exp_data) begin errs++; $display("[TB] FAIL fair_data_%0d: got %h want %h", t, rsp1_rdata, exp_data); end
      end
      if (t == 0) begin
        vec++; if (rsp1_rdata !== 32'h0) begin errs++; $display("[TB] FAIL fair_hold1: got %h want 0", rsp1_rdata); end
      end
      if (t == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
    end
    tick;
  endtask

  task automatic test_late_arrival;
    int c0, c1;
    c0 = rsp0_cnt; c1 = rsp1_cnt;
    req1_valid = 1; req1_we = 0; req1_addr = 7;
    #1;
    vec++; if ({req1_ready, req0_ready} !== 2'b10) begin errs++; $display("[TB] FAIL late_grant1: got %b want 10", {req1_ready, req0_ready}); end
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_we = 0; req0_addr = 4;
    #1;
    vec++; if (req0_ready !== 1'b0) begin errs++; $display("[TB] FAIL late_ready0_busy: got %b want 0", req0_ready); end
    tick;
    vec++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h1000_0007) begin errs++; $display("[TB] FAIL late_rsp1: valid %b data %h want 1/10000007", rsp1_valid, rsp1_rdata); end
    #1;
    vec++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL late_ready0: got %b want 1", req0_ready); end
    tick;
    req0_valid = 0;
    tick;
    vec++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'h1000_0004) begin errs++; $display("[TB] FAIL late_rsp0: v0 %b v1 %b data %h want 1/0/10000004", rsp0_valid, rsp1_valid, rsp0_rdata); end
    tick;
    vec++; if (rsp0_cnt - c0 !== 1 || rsp1_cnt - c1 !== 1) begin errs++; $display("[TB] FAIL late_counts: got %0d/%0d want 1/1", rsp0_cnt - c0, rsp1_cnt - c1); end
  endtask

  task automatic test_reset_mid;
    int c0, c1;
    req0_valid = 1; req0_we = 1; req0_addr = 9; req0_wdata = 32'h1234_5678; req0_be = 4'hF;
    tick;
    req0_valid = 0;
    vec++; if (mem_we !== 1'b1) begin errs++; $display("[TB] FAIL rstmid_access: got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    vec++; if (mem_we !== 1'b0) begin errs++; $display("[TB] FAIL rstmid_we_async: got %b want 0", mem_we); end
    c0 = rsp0_cnt; c1 = rsp1_cnt;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    tick;
    tick;
    vec++; if (rsp0_cnt !== c0 || rsp1_cnt !== c1) begin errs++; $display("[TB] FAIL rstmid_no_rsp: got %0d/%0d want %0d/%0d", rsp0_cnt, rsp1_cnt, c0, c1); end
    vec++; if (mem[9] !== 32'h1000_0009) begin errs++; $display("[TB] FAIL rstmid_no_write: got %h want 10000009", mem[9]); end
    req0_valid = 1; req0_we = 0; req0_addr = 1;
    req1_valid = 1; req1_we = 0; req1_addr = 2;
    #1;
    vec++; if ({req1_ready, req0_ready} !== 2'b01) begin errs++; $display("[TB] FAIL rstmid_priority: got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 0; req1_valid = 0;
    tick;
  endtask

  task automatic test_subword;
    logic [31:0] exp_word;
    req0_valid = 1; req0_we = 1; req0_addr = 3; req0_wdata = 32'h1122_3344; req0_be = 4'hF;
    tick;
    req0_valid = 0;
    tick;
    req0_valid = 1; req0_we = 1; req0_addr = 3; req0_wdata = 32'h0000_AA00; req0_be = 4'b0010;
    #1;
    vec++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL sub_ready: got %b want 1", req0_ready); end
    tick;
    req0_valid = 0; req0_be = 4'hF;
`ifdef DMEM_ARB_SUBWORD_EN
    exp_word = 32'h1122_AA44;
    vec++; if (mem_we !== 1'b0) begin errs++; $display("[TB] FAIL sub_read_phase: got %b want 0", mem_we); end
    tick;
    vec++; if (rsp0_valid !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h1122_AA44) begin errs++; $display("[TB] FAIL sub_rmw_wr: v %b we %b data %h want 0/1/1122aa44", rsp0_valid, mem_we, mem_wdata); end
    tick;
`else
    exp_word = 32'h0000_AA00;
    vec++; if (mem_we !== 1'b1 || mem_wdata !== 32'h0000_AA00) begin errs++; $display("[TB] FAIL sub_full_wr: we %b data %h want 1/0000aa00", mem_we, mem_wdata); end
    tick;
`endif
    vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h1122_3344) begin errs++; $display("[TB] FAIL sub_rsp: v %b data %h want 1/11223344", rsp0_valid, rsp0_rdata); end
    req0_valid = 1; req0_we = 0; req0_addr = 3;
    tick;
    req0_valid = 0;
    tick;
    vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== exp_word) begin errs++; $display("[TB] FAIL sub_readback: v %b data %h want 1/%h", rsp0_valid, rsp0_rdata, exp_word); end
    tick;
  endtask

  task automatic test_ordering;
    req1_valid = 1; req1_we = 1; req1_addr = 0; req1_wdata = 32'hCAFE_F00D; req1_be = 4'hF;
    #1;
    vec++; if (req1_ready !== 1'b1) begin errs++; $display("[TB] FAIL ord_ready1: got %b want 1", req1_ready); end
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_we = 0; req0_addr = 0;
    tick;
    vec++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h1000_0000) begin errs++; $display("[TB] FAIL ord_rsp1: v %b data %h want 1/10000000", rsp1_valid, rsp1_rdata); end
    #1;
    vec++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL ord_ready0: got %b want 1", req0_ready); end
    tick;
    req0_valid = 0;
    vec++; if (mem_addr !== 32'd0 || mem_we !== 1'b0) begin errs++; $display("[TB] FAIL ord_access: addr %h we %b want 0/0", mem_addr, mem_we); end
    tick;
    vec++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hCAFE_F00D) begin errs++; $display("[TB] FAIL ord_rsp0: v %b data %h want 1/cafef00d", rsp0_valid, rsp0_rdata); end
    tick;
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_write_read();
    test_fairness();
    test_late_arrival();
    test_reset_mid();
    test_subword();
    test_ordering();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
